// File: rtl/lsu_align.sv
// lsu_align: load/store alignment unit between the pipeline and a single-port memory.
// Aligned accesses become one memory transaction with byte enables and lane-replicated
// store data. Misaligned accesses raise an address exception. A wait counter bounds
// how long a transaction may stay outstanding.
module lsu_align #(
  parameter int DW       = 32,
  parameter int AW       = 32,
  parameter int WAIT_MAX = 15
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic            req_store,
  input  logic [1:0]      req_size,
  input  logic            req_unsigned,
  input  logic [AW-1:0]   req_addr,
  input  logic [DW-1:0]   req_wdata,
  input  logic            flush,
  output logic            mem_req,
  output logic            mem_we,
  output logic [AW-1:0]   mem_addr,
  output logic [DW/8-1:0] mem_be,
  output logic [DW-1:0]   mem_wdata,
  input  logic            mem_ack,
  input  logic [DW-1:0]   mem_rdata,
  output logic            rsp_valid,
  output logic [DW-1:0]   rsp_rdata,
  output logic            stall,
  output logic            exc_adel,
  output logic            exc_ades,
  output logic [AW-1:0]   exc_badvaddr,
  output logic            timeout
);
  localparam int NB = DW / 8;
  localparam int LB = $clog2(NB);

  typedef enum logic {IDLE, WAIT} state_t;

  // Memory-side request, held stable for the whole WAIT phase.
  typedef struct packed {
    logic          we;
    logic [AW-1:0] addr;
    logic [NB-1:0] be;
    logic [DW-1:0] wdata;
  } mreq_t;

  // What the response path needs to remember about the accepted access.
  typedef struct packed {
    logic          st;
    logic          uns;
    logic [1:0]    size;
    logic [LB-1:0] ofs;
  } ctx_t;

  state_t          state_q, state_d;
  logic [7:0]      cnt_q, cnt_d;
  logic            flush_q, flush_d;
  logic            mem_req_q, mem_req_d;
  mreq_t           mem_q, mem_d;
  ctx_t            ctx_q, ctx_d;
  logic            rsp_valid_q, rsp_valid_d;
  logic [DW-1:0]   rsp_rdata_q, rsp_rdata_d;
  logic            exc_adel_q, exc_adel_d;
  logic            exc_ades_q, exc_ades_d;
  logic [AW-1:0]   exc_badvaddr_q, exc_badvaddr_d;
  logic            timeout_q, timeout_d;

  // Request decode
  logic [LB-1:0]   ofs;
  logic [2:0]      szm;      // access size in bytes minus one
  logic            misal;
  logic [NB-1:0]   be_base;
  logic [DW-1:0]   wrep;

  assign ofs     = req_addr[LB-1:0];
  assign szm     = (3'd1 << req_size) - 3'd1;
  assign misal   = ((ofs & szm[LB-1:0]) != '0) || (DW == 32 && req_size == 2'b11);
  assign be_base = NB'((16'd1 << (5'd1 << req_size)) - 16'd1);

  // Each byte lane picks the store byte at (lane mod size), replicating the datum.
  for (genvar b = 0; b < NB; b++) begin : g_lane
    logic [LB-1:0] sel;
    assign sel              = LB'(b) & szm[LB-1:0];
    assign wrep[8*b +: 8]   = req_wdata[{sel, 3'b000} +: 8];
  end

  // Load extraction: shift the addressed bytes down, keep SZ bytes, extend.
  logic [DW-1:0] ld_sh, ld_keep, ld_top, ld_data;
  logic          ld_sbit;
  always_comb begin
    ld_sh   = mem_rdata >> {ctx_q.ofs, 3'b000};
    ld_keep = ~({DW{1'b1}} << (7'd8 << ctx_q.size));
    ld_top  = ld_keep & ~(ld_keep >> 1);
    ld_sbit = |(ld_sh & ld_top) & ~ctx_q.uns;
    ld_data = (ld_sh & ld_keep) | ({DW{ld_sbit}} & ~ld_keep);
  end

  // Next-state and registered-output logic for the IDLE/WAIT controller.
  always_comb begin
    state_d        = state_q;
    cnt_d          = cnt_q;
    flush_d        = flush_q;
    mem_req_d      = mem_req_q;
    mem_d          = mem_q;
    ctx_d          = ctx_q;
    rsp_valid_d    = 1'b0;
    rsp_rdata_d    = rsp_rdata_q;
    exc_adel_d     = 1'b0;
    exc_ades_d     = 1'b0;
    exc_badvaddr_d = exc_badvaddr_q;
    timeout_d      = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (req_valid && !flush) begin
          if (misal) begin
            exc_adel_d     = ~req_store;
            exc_ades_d     = req_store;
            exc_badvaddr_d = req_addr;
          end else begin
            state_d     = WAIT;
            cnt_d       = '0;
            flush_d     = 1'b0;
            mem_req_d   = 1'b1;
            mem_d.we    = req_store;
            mem_d.addr  = req_addr & ~AW'(NB - 1);
            mem_d.be    = be_base << ofs;
            mem_d.wdata = req_store ? wrep : '0;
            ctx_d       = '{st: req_store, uns: req_unsigned, size: req_size, ofs: ofs};
          end
        end
      end
      WAIT: begin
        if (mem_ack) begin
          // Ack beats a simultaneous timeout; a flush seen at any point drops the response.
          state_d   = IDLE;
          mem_req_d = 1'b0;
          flush_d   = 1'b0;
          if (!(flush_q || flush)) begin
            rsp_valid_d = 1'b1;
            rsp_rdata_d = ctx_q.st ? '0 : ld_data;
          end
        end else if (cnt_q + 8'd1 == 8'(WAIT_MAX)) begin
          state_d   = IDLE;
          mem_req_d = 1'b0;
          flush_d   = 1'b0;
          cnt_d     = cnt_q + 8'd1;
          timeout_d = 1'b1;
        end else begin
          cnt_d   = cnt_q + 8'd1;
          flush_d = flush_q | flush;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= IDLE;
      cnt_q          <= '0;
      flush_q        <= 1'b0;
      mem_req_q      <= 1'b0;
      mem_q          <= '0;
      ctx_q          <= '0;
      rsp_valid_q    <= 1'b0;
      rsp_rdata_q    <= '0;
      exc_adel_q     <= 1'b0;
      exc_ades_q     <= 1'b0;
      exc_badvaddr_q <= '0;
      timeout_q      <= 1'b0;
    end else begin
      state_q        <= state_d;
      cnt_q          <= cnt_d;
      flush_q        <= flush_d;
      mem_req_q      <= mem_req_d;
      mem_q          <= mem_d;
      ctx_q          <= ctx_d;
      rsp_valid_q    <= rsp_valid_d;
      rsp_rdata_q    <= rsp_rdata_d;
      exc_adel_q     <= exc_adel_d;
      exc_ades_q     <= exc_ades_d;
      exc_badvaddr_q <= exc_badvaddr_d;
      timeout_q      <= timeout_d;
    end
  end

  assign req_ready    = (state_q == IDLE) && !rst;
  assign stall        = (state_q == WAIT) && !rst;
  assign mem_req      = mem_req_q;
  assign mem_we       = mem_q.we;
  assign mem_addr     = mem_q.addr;
  assign mem_be       = mem_q.be;
  assign mem_wdata    = mem_q.wdata;
  assign rsp_valid    = rsp_valid_q;
  assign rsp_rdata    = rsp_rdata_q;
  assign exc_adel     = exc_adel_q;
  assign exc_ades     = exc_ades_q;
  assign exc_badvaddr = exc_badvaddr_q;
  assign timeout      = timeout_q;
endmodule

// File: tb/tb_lsu_align.sv
// Scoreboard bench for lsu_align (DW=32, WAIT_MAX=4): the driver predicts every
// memory access, response, exception and timeout; a monitor pops and compares.
module tb_lsu_align;
  logic        clk = 0, rst = 1;
  logic        req_valid = 0, req_ready, req_store = 0, req_unsigned = 0, flush = 0;
  logic [1:0]  req_size = 0;
  logic [31:0] req_addr = 0, req_wdata = 0;
  logic        mem_req, mem_we, mem_ack = 0;
  logic [31:0] mem_addr, mem_wdata, mem_rdata = 0;
  logic [3:0]  mem_be;
  logic        rsp_valid, stall, exc_adel, exc_ades, timeout;
  logic [31:0] rsp_rdata, exc_badvaddr;

  lsu_align #(.DW(32), .AW(32), .WAIT_MAX(4)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .req_store(req_store), .req_size(req_size), .req_unsigned(req_unsigned),
    .req_addr(req_addr), .req_wdata(req_wdata), .flush(flush),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_be(mem_be),
    .mem_wdata(mem_wdata), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .stall(stall),
    .exc_adel(exc_adel), .exc_ades(exc_ades), .exc_badvaddr(exc_badvaddr),
    .timeout(timeout));

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct { logic [31:0] addr; logic [3:0] be; logic we; logic [31:0] wdata; int start; int fin; } acc_t;
  typedef struct { logic [31:0] rdata; int cyc; } rsp_t;
  typedef struct { logic adel; logic ades; logic [31:0] va; int cyc; } exc_t;

  acc_t acc_q[$];
  rsp_t rsp_q[$];
  exc_t exc_q[$];
  int   tmo_q[$];

  int n_vec = 0, n_bad = 0;
  logic [31:0] last_va = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Monitor: compare every DUT-presented event against the scoreboard queues.
  acc_t cur;
  rsp_t r;
  exc_t e;
  int   tc;
  bit   prev_req = 0;
  always @(negedge clk) if (cyc > 0) begin
    if (mem_req && !prev_req) begin
      if (acc_q.size() == 0) chk("spurious mem_req", mem_req, 0);
      else begin
        cur = acc_q.pop_front();
        chk("mem_addr", mem_addr, cur.addr);
        chk("mem_be", mem_be, cur.be);
        chk("mem_we", mem_we, cur.we);
        chk("mem_wdata", mem_wdata, cur.wdata);
        chk("mem_req start cycle", cyc, cur.start);
      end
    end else if (mem_req) begin
      chk("mem hold ctl", {mem_we, mem_be, mem_addr}, {cur.we, cur.be, cur.addr});
      chk("mem hold wdata", mem_wdata, cur.wdata);
    end
    if (!mem_req && prev_req) chk("mem_req end cycle", cyc, cur.fin);
    prev_req = mem_req;
    if (rsp_valid) begin
      if (rsp_q.size() == 0) chk("spurious rsp_valid", rsp_valid, 0);
      else begin
        r = rsp_q.pop_front();
        chk("rsp_rdata", rsp_rdata, r.rdata);
        chk("rsp cycle", cyc, r.cyc);
      end
    end
    if (exc_adel || exc_ades) begin
      if (exc_q.size() == 0) chk("spurious exception", {exc_adel, exc_ades}, 0);
      else begin
        e = exc_q.pop_front();
        chk("exc kind", {exc_adel, exc_ades}, {e.adel, e.ades});
        chk("exc_badvaddr", exc_badvaddr, e.va);
        chk("exc cycle", cyc, e.cyc);
      end
    end
    if (timeout) begin
      if (tmo_q.size() == 0) chk("spurious timeout", timeout, 0);
      else begin
        tc = tmo_q.pop_front();
        chk("timeout cycle", cyc, tc);
      end
    end
  end

  // Reference model helpers (plain arithmetic on the access rules).
  function automatic logic [31:0] exp_load(logic [31:0] rd, int ofs, int nb, bit un);
    logic [31:0] sh, mask;
    mask = (nb >= 4) ? 32'hFFFF_FFFF : ((32'h1 << (8 * nb)) - 1);
    sh   = (rd >> (8 * ofs)) & mask;
    if (!un && sh[8 * nb - 1]) sh = sh | ~mask;
    return sh;
  endfunction

  function automatic logic [31:0] exp_store(logic [31:0] wd, int nb);
    logic [31:0] mask, rep;
    mask = (nb >= 4) ? 32'hFFFF_FFFF : ((32'h1 << (8 * nb)) - 1);
    rep  = (nb == 1) ? 32'h0101_0101 : (nb == 2) ? 32'h0001_0001 : 32'h1;
    return (wd & mask) * rep;
  endfunction

  task automatic wait_ready();
    int n = 0;
    while (!req_ready && n < 20) begin @(negedge clk); n++; end
    if (!req_ready) chk("req_ready wait", req_ready, 1);
  endtask

  // One request. w = idle cycles before ack (w<=3 ack, 4 never, 5 late ack in IDLE).
  task automatic do_txn(input bit st, input logic [1:0] sz, input logic [31:0] addr,
                        input logic [31:0] wd, input bit un, input logic [31:0] rd,
                        input int w, input bit fl_acc, input bit fl_wait, input int fk);
    int a, nb, ofs, last;
    bit mis;
    wait_ready();
    req_valid = 1; req_store = st; req_size = sz; req_addr = addr;
    req_wdata = wd; req_unsigned = un; flush = fl_acc; mem_ack = 0;
    @(negedge clk);
    a = cyc; req_valid = 0; flush = 0;
    nb  = 1 << sz;
    ofs = int'(addr[1:0]);
    mis = (ofs % nb) != 0 || nb > 4;
    if (fl_acc) begin
      chk("ready after flushed req", req_ready, 1);
      return;
    end
    if (mis) begin
      exc_q.push_back('{!st, st, addr, a});
      last_va = addr;
      chk("ready after exception", req_ready, 1);
      return;
    end
    last = (w <= 3) ? w : (w == 4 ? 3 : w);
    acc_q.push_back('{addr & 32'hFFFF_FFFC, 4'(((1 << nb) - 1) << ofs), st,
                      st ? exp_store(wd, nb) : 32'h0, a, (w <= 3) ? a + w + 1 : a + 4});
    if (w <= 3) begin
      if (!fl_wait) rsp_q.push_back('{st ? 32'h0 : exp_load(rd, ofs, nb, un), a + w + 1});
    end else tmo_q.push_back(a + 4);
    chk("stall in WAIT", stall, 1);
    chk("req_ready in WAIT", req_ready, 0);
    for (int k = 0; k <= last; k++) begin
      mem_ack   = (k == w);
      mem_rdata = (k == w) ? rd : $urandom;
      flush     = fl_wait && (k == fk);
      @(negedge clk);
    end
    mem_ack = 0; flush = 0;
    chk("ready after access", req_ready, 1);
    chk("stall after access", stall, 0);
    chk("badvaddr held", exc_badvaddr, last_va);
  endtask

  task automatic rst_mid();
    int a;
    wait_ready();
    req_valid = 1; req_store = 0; req_size = 2; req_addr = 32'h3000; req_unsigned = 0;
    @(negedge clk);
    a = cyc; req_valid = 0;
    acc_q.push_back('{32'h3000, 4'hF, 1'b0, 32'h0, a, a + 2});
    @(negedge clk);
    rst = 1; mem_ack = 1; mem_rdata = 32'hDEAD_BEEF;
    @(negedge clk);
    chk("rst mem_req", mem_req, 0);
    chk("rst mem ctl", {mem_we, mem_be, mem_addr}, 0);
    chk("rst mem_wdata", mem_wdata, 0);
    chk("rst rsp", {rsp_valid, rsp_rdata}, 0);
    chk("rst exc", {exc_adel, exc_ades, exc_badvaddr, timeout}, 0);
    chk("rst ready/stall", {req_ready, stall}, 0);
    rst = 0; last_va = 0;
    @(negedge clk);
    mem_ack = 0;
    chk("ready after mid rst", req_ready, 1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(negedge clk);
    chk("reset ready/stall", {req_ready, stall}, 0);
    chk("reset mem", {mem_req, mem_we, mem_be, mem_addr}, 0);
    chk("reset outputs", {rsp_valid, exc_adel, exc_ades, timeout, exc_badvaddr}, 0);
    rst = 0;
    @(negedge clk);
    chk("ready out of reset", req_ready, 1);
    // Directed cases
    do_txn(1, 2'b00, 32'h1003, 32'h0000_00AB, 0, 0, 2, 0, 0, 0);           // SB replicated
    do_txn(0, 2'b00, 32'h2001, 0, 0, 32'h1234_8056, 0, 0, 0, 0);          // LB sign
    do_txn(0, 2'b00, 32'h2001, 0, 1, 32'h1234_8056, 1, 0, 0, 0);          // LBU
    do_txn(0, 2'b01, 32'h2002, 0, 0, 32'h1234_8056, 0, 0, 0, 0);          // LH upper
    do_txn(0, 2'b01, 32'h2003, 0, 0, 0, 0, 0, 0, 0);                      // LH misaligned
    do_txn(1, 2'b10, 32'h2002, 32'h5555_AAAA, 0, 0, 0, 0, 0, 0);          // SW misaligned
    do_txn(0, 2'b11, 32'h2000, 0, 0, 0, 0, 0, 0, 0);                      // dword on 32-bit
    do_txn(0, 2'b10, 32'h4000, 0, 0, 32'hCAFE_F00D, 4, 0, 0, 0);          // timeout
    do_txn(0, 2'b10, 32'h4004, 0, 0, 32'h0BAD_0BAD, 5, 0, 0, 0);          // timeout, late ack ignored
    do_txn(0, 2'b10, 32'h4008, 0, 0, 32'h8765_4321, 3, 0, 0, 0);          // ack on limit wins
    do_txn(0, 2'b10, 32'h400C, 0, 0, 32'h1111_2222, 3, 0, 1, 0);          // flush in WAIT
    do_txn(1, 2'b01, 32'h5002, 32'h0000_BEEF, 0, 0, 0, 0, 0, 0);          // back-to-back SH
    do_txn(0, 2'b01, 32'h5001, 0, 0, 0, 0, 1, 0, 0);                      // flushed misaligned
    do_txn(0, 2'b10, 32'h5000, 0, 0, 0, 0, 1, 0, 0);                      // flushed aligned
    rst_mid();
    // Randomized traffic
    for (int i = 0; i < 250; i++) begin
      int w, fk;
      w  = $urandom_range(0, 5);
      fk = $urandom_range(0, (w < 3) ? w : 3);
      do_txn($urandom_range(0, 1), 2'($urandom_range(0, 3)), $urandom, $urandom,
             $urandom_range(0, 1), $urandom, w, $urandom_range(0, 9) == 0,
             $urandom_range(0, 4) == 0, fk);
    end
    repeat (4) @(negedge clk);
    chk("pending accesses", acc_q.size(), 0);
    chk("pending responses", rsp_q.size(), 0);
    chk("pending exceptions", exc_q.size(), 0);
    chk("pending timeouts", tmo_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
